// File: rtl/ram_pkg.sv
// Shared definitions for the RAM request master.
// Holds the controller state type, the response buffer depth and a word-count helper.
package ram_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Read responses that may be outstanding (in flight + buffered) at once.
  localparam int unsigned RSP_DEPTH = 2;

  // Number of words addressed by a depth-bit address.
  function automatic int unsigned num_words(input int unsigned depth);
    return 32'(1) << depth;
  endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO for read data.
// Ports: clk, rst_n; push/push_data write the tail; pop drops the head;
//        count = occupancy; head = oldest entry, or the last popped word when empty.
module rsp_fifo2
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic [WIDTH-1:0]                   push_data,
  input  logic                               pop,
  output logic [$clog2(RSP_DEPTH+1)-1:0]     count,
  output logic [WIDTH-1:0]                   head
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);

  logic [RSP_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [WIDTH-1:0]                last_q, last_d;

  // Pointer/count update; push and pop in the same cycle keep the count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // Empty FIFO keeps presenting the last delivered word.
  assign count = cnt_q;
  assign head  = (cnt_q != '0) ? mem_q[rd_ptr_q] : last_q;

endmodule

// File: rtl/ram_req_master.sv
// Initiator for a single-port synchronous RAM with 1-cycle registered reads.
// Ports: req_* valid/ready request stream (read or write); rsp_* valid/ready read
//        data stream in request order; ram_* RAM port; busy = sweep active or
//        read data outstanding. Optional post-reset sweep fills the RAM with CLEAR_VALUE.
module ram_req_master
  import ram_pkg::*;
#(
  parameter int unsigned     WIDTH          = 8,
  parameter int unsigned     DEPTH          = 4,
  parameter int unsigned     CLEAR_ON_RESET = 0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [DEPTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             ram_enable,
  output logic             ram_wr_en,
  output logic [DEPTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out,
  output logic             busy
);

  localparam int unsigned NUM_WORDS   = num_words(DEPTH);
  localparam int unsigned CNT_W       = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PEND_W      = CNT_W + 1;
  localparam state_e      RESET_STATE = (CLEAR_ON_RESET != 0) ? SWEEP : RUN;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic             pop_c;
  logic             fire_c;
  logic [PEND_W-1:0] pending_c;

  rsp_fifo2 #(.WIDTH(WIDTH)) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (ram_data_out),
    .pop       (pop_c),
    .count     (fifo_count),
    .head      (rsp_rdata)
  );

  assign rsp_valid = (fifo_count != '0);
  assign pop_c     = rsp_valid & rsp_ready;
  assign busy      = (state_q == SWEEP) | inflight_q | rsp_valid;

  // Outstanding reads after this cycle's pop; a same-cycle pop frees its credit
  // so back-to-back reads keep full throughput.
  assign pending_c = PEND_W'(fifo_count) + PEND_W'(inflight_q) - PEND_W'(pop_c);

  // Next state and RAM drive; the port stays quiet while reset is held.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    inflight_d  = 1'b0;
    req_ready   = 1'b0;
    fire_c      = 1'b0;
    ram_enable  = 1'b0;
    ram_wr_en   = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    if (rst_n) begin
      case (state_q)
        SWEEP: begin
          ram_enable  = 1'b1;
          ram_wr_en   = 1'b1;
          ram_address = sweep_cnt_q;
          ram_data_in = CLEAR_VALUE;
          sweep_cnt_d = sweep_cnt_q + DEPTH'(1);
          if (sweep_cnt_q == DEPTH'(NUM_WORDS - 1)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Read credit rule applied to every request, writes included.
          req_ready  = (pending_c < PEND_W'(RSP_DEPTH));
          fire_c     = req_valid & req_ready;
          ram_enable = fire_c;
          ram_wr_en  = fire_c & req_wr;
          if (fire_c) begin
            ram_address = req_addr;
            ram_data_in = req_wdata;
          end
          inflight_d = fire_c & ~req_wr;
        end
        default: state_d = RESET_STATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      sweep_cnt_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_ram_req_master.sv
// Self-checking bench for ram_req_master with a behavioural RAM and a
// transaction-level model of expected RAM contents and pending read responses.
module tb_ram_req_master;

  localparam int unsigned NW = 16;
  localparam logic [7:0]  CV = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid, req_ready, req_wr;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       ram_enable, ram_wr_en;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in, ram_data_out;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  ram_req_master #(
    .WIDTH(8), .DEPTH(4), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_enable(ram_enable), .ram_wr_en(ram_wr_en), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, registered read; starts with non-clear contents.
  logic [7:0] ram_mem [NW];
  logic [7:0] ram_dout = 8'h00;
  assign ram_data_out = ram_dout;
  initial for (int i = 0; i < NW; i++) ram_mem[i] = 8'hA5;
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_wr_en) ram_mem[ram_address] <= ram_data_in;
      else           ram_dout <= ram_mem[ram_address];
    end
  end

  // Reference model: expected RAM contents and ordered pending read responses.
  logic [7:0] shadow [NW];
  int exp_d[$];
  int exp_c[$];
  int cyc = 0;
  bit mon_en = 1'b0;
  int rsp_cnt = 0;
  int m_pend;
  bit m_vis, m_pop;

  // A read handshaken at negedge N has its data visible from negedge N+2.
  always @(negedge clk) begin
    cyc++;
    if (mon_en && rst_n) begin
      m_pend = exp_d.size();
      m_vis  = (m_pend != 0) && (exp_c[0] + 2 <= cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_vis));
      m_pop  = m_vis && rsp_ready;
      chk("req_ready", 32'(req_ready), 32'(((m_pend - int'(m_pop)) < 2)));
      chk("busy", 32'(busy), 32'(m_pend != 0));
      if (m_pop && rsp_valid) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_d.pop_front()));
        void'(exp_c.pop_front());
        rsp_cnt++;
      end
      if (req_valid && req_ready) begin
        chk("ram_en", 32'(ram_enable), 32'(1));
        chk("ram_wr", 32'(ram_wr_en), 32'(req_wr));
        chk("ram_addr", 32'(ram_address), 32'(req_addr));
        chk("ram_din", 32'(ram_data_in), 32'(req_wdata));
        if (req_wr) shadow[req_addr] = req_wdata;
        else begin
          exp_d.push_back(int'(shadow[req_addr]));
          exp_c.push_back(cyc);
        end
      end else begin
        chk("idle_en", 32'(ram_enable), 32'(0));
        chk("idle_wr", 32'(ram_wr_en), 32'(0));
        chk("idle_addr", 32'(ram_address), 32'(0));
        chk("idle_din", 32'(ram_data_in), 32'(0));
      end
    end
  end

  task automatic sweep_and_arm();
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk($sformatf("sw_en%0d", i), 32'(ram_enable), 32'(1));
      chk($sformatf("sw_wr%0d", i), 32'(ram_wr_en), 32'(1));
      chk($sformatf("sw_addr%0d", i), 32'(ram_address), 32'(i));
      chk($sformatf("sw_din%0d", i), 32'(ram_data_in), 32'(CV));
      chk($sformatf("sw_rdy%0d", i), 32'(req_ready), 32'(0));
      chk($sformatf("sw_busy%0d", i), 32'(busy), 32'(1));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int a = 0; a < NW; a++) shadow[a] = CV;
    mon_en = 1'b1;
  endtask

  task automatic do_req(input logic wr, input logic [3:0] a, input logic [7:0] d, output int waits);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) chk("req_accept", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 4'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_d.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(exp_d.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 reached");
    $fatal(1, "watchdog");
  end

  int w;
  int rc;

  initial begin
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    chk("rst_ram_en", 32'(ram_enable), 32'(0));
    chk("rst_ram_wr", 32'(ram_wr_en), 32'(0));
    chk("rst_ram_addr", 32'(ram_address), 32'(0));
    chk("rst_ram_din", 32'(ram_data_in), 32'(0));
    chk("rst_busy", 32'(busy), 32'(1));

    // Post-reset sweep with a request offered throughout
    rst_n = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'h9; req_wdata = 8'h5A;
    sweep_and_arm();

    // Sweep result: first and last words cleared
    rsp_ready = 1'b1;
    do_req(1'b0, 4'd0, 8'h00, w);
    do_req(1'b0, 4'd15, 8'h00, w);
    drain();

    // Write then read same address on consecutive cycles
    do_req(1'b1, 4'd5, 8'hFF, w);
    do_req(1'b0, 4'd5, 8'h00, w);
    @(negedge clk);
    chk("lat_inflight", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    chk("lat_valid", 32'(rsp_valid), 32'(1));
    chk("lat_data", 32'(rsp_rdata), 32'(8'hFF));
    drain();

    // Back-to-back reads with an always-ready consumer
    for (int i = 0; i < 4; i++) do_req(1'b1, 4'(i), 8'(8'h10 + i), w);
    rc = rsp_cnt;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 4'(i), 8'h00, w);
      chk($sformatf("b2b_stall%0d", i), 32'(w), 32'(0));
    end
    drain();
    chk("b2b_count", 32'(rsp_cnt - rc), 32'(4));

    // Response backpressure: third read held until a pop frees a credit
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd0;
    @(negedge clk); chk("bp_rdy0", 32'(req_ready), 32'(1));
    @(posedge clk); #1; req_addr = 4'd1;
    @(negedge clk); chk("bp_rdy1", 32'(req_ready), 32'(1));
    @(posedge clk); #1; req_addr = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_full", 32'(req_ready), 32'(0));
      chk("bp_no_ram", 32'(ram_enable), 32'(0));
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk); chk("bp_resume", 32'(req_ready), 32'(1));
    @(posedge clk); #1; req_valid = 1'b0;
    drain();

    // Asynchronous reset with one read buffered and one in flight
    rsp_ready = 1'b0;
    do_req(1'b0, 4'd3, 8'h00, w);
    do_req(1'b0, 4'd4, 8'h00, w);
    chk("ar_pre_valid", 32'(rsp_valid), 32'(1));
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(rsp_valid), 32'(0));
    chk("ar_ready", 32'(req_ready), 32'(0));
    chk("ar_ram_en", 32'(ram_enable), 32'(0));
    chk("ar_busy", 32'(busy), 32'(1));
    exp_d.delete();
    exp_c.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd7; req_wdata = 8'h77;
    sweep_and_arm();
    repeat (6) @(posedge clk);
    #1;

    // Idle in RUN with non-zero request fields
    req_valid = 1'b0; req_addr = 4'hB; req_wdata = 8'hC3;
    @(negedge clk);
    chk("idle_ram_en", 32'(ram_enable), 32'(0));
    chk("idle_ram_addr", 32'(ram_address), 32'(0));
    chk("idle_ram_din", 32'(ram_data_in), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;

    // Randomized traffic with random consumer backpressure
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_wr    = ($urandom_range(0, 99) < 40);
      req_addr  = 4'($urandom);
      req_wdata = 8'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 65);
      @(posedge clk); #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
